// File: rtl/eth_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared definitions for the Ethernet transmit framing path:
//   - state_t       : framer FSM states
//   - PREAMBLE_BYTE,
//     SFD_BYTE      : wire-level preamble / start-of-frame delimiter bytes
//   - CRC_POLY_REFL,
//     CRC_INIT      : reflected CRC-32 polynomial and seed
//   - CKE, FRM      : bit positions inside the 10-bit {CKE, FRM, DAT} stream
//   - crc32_d8()    : one-byte reflected CRC-32 update, LSB first
// -----------------------------------------------------------------------------
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAD  = 3'd3,
        FCS  = 3'd4,
        IFG  = 3'd5
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    localparam int CKE = 9;
    localparam int FRM = 8;

    // Bit-serial reflected CRC-32 over one byte, least significant bit first.
    // No final inversion: callers invert when they emit the FCS.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc,
                                             input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// -----------------------------------------------------------------------------
// eth_crc32_d8
// Combinational next-CRC for one byte of a reflected CRC-32 (Ethernet FCS).
// Shared between the TX framer and the RX CRC checker.
// Ports:
//   crc_prev  in  32  running CRC register before this byte
//   data      in   8  byte to fold in (processed LSB first)
//   crc_upd   out 32  running CRC register after this byte
// -----------------------------------------------------------------------------
module eth_crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_prev,
    input  logic [7:0]  data,
    output logic [31:0] crc_upd
);

    assign crc_upd = crc32_d8(crc_prev, data);

endmodule

// File: rtl/eth_tx_framer.sv
// -----------------------------------------------------------------------------
// eth_tx_framer
// Transmit framing stage between the packet engine and the GE MAC. Takes frame
// bytes (destination MAC .. payload) on a 10-bit {CKE, FRM, DAT} stream and
// emits the full wire frame: preamble, SFD, data, zero pad up to the minimum
// length, CRC-32 FCS, followed by a forced inter-frame gap. Every internal
// update happens on input CKE beats only, so the input pacing (every clock at
// 1000 Mbps, one clock in ten at 100 Mbps) is carried straight through.
// Ports:
//   CLK             in   1  system clock
//   RST             in   1  synchronous active-high reset
//   IN_ETH_STREAM   in  10  {CKE, FRM, DAT} frame bytes, no preamble / FCS
//   OUT_ETH_STREAM  out 10  {CKE, FRM, DAT} wire frame, CKE delayed one clock
//   BUSY            out  1  framer is not idle; upstream waits for it to drop
//   DROP_CNT        out 16  saturating count of rejected input frames
// -----------------------------------------------------------------------------
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_BYTES     = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  IN_ETH_STREAM,
    output logic [9:0]  OUT_ETH_STREAM,
    output logic        BUSY,
    output logic [15:0] DROP_CNT
);

    // The delay line is one deeper than the preamble so that the first data
    // byte arrives at the tail on exactly the SFD beat.
    localparam int          DL_DEPTH = PREAMBLE_LEN + 1;
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    logic        in_cke;
    logic        in_frm;
    logic [7:0]  in_dat;

    state_t      state_reg, state_next;
    logic        prev_frm_reg;
    logic        wait_low_reg;
    logic        acc_reg, acc_next;
    logic [7:0]  pre_cnt_reg, pre_cnt_next;
    logic [10:0] byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
    logic [31:0] crc_reg, crc_next, crc_upd;
    logic [7:0]  crc_byte;
    logic [1:0]  fcs_idx_reg, fcs_idx_next;
    logic [7:0]  ifg_cnt_reg, ifg_cnt_next;
    logic [15:0] drop_cnt_reg;
    logic [9:0]  out_reg;
    logic        out_frm_next;
    logic [7:0]  out_dat_next;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    logic [DL_DEPTH-1:0][8:0] dl_reg, dl_next;
    logic [8:0]  dl_push;
    logic [8:0]  dl_tail;

    logic        frm_rise;
    logic        accept;
    logic        reject;

    assign in_cke = IN_ETH_STREAM[CKE];
    assign in_frm = IN_ETH_STREAM[FRM];
    assign in_dat = IN_ETH_STREAM[7:0];

    // wait_low_reg masks a frame that was already running when reset released:
    // nothing is treated as a start of frame until FRM has been seen low once.
    assign frm_rise = in_frm & ~prev_frm_reg & ~wait_low_reg;
    assign accept   = frm_rise & (state_reg == IDLE);
    assign reject   = frm_rise & (state_reg != IDLE);

    // acc_next stays high for the rest of an accepted frame and falls with FRM;
    // beats of rejected frames never enter the delay line.
    assign acc_next = in_frm & (acc_reg | accept);
    assign dl_push  = acc_next ? {1'b1, in_dat} : 9'h000;

    // ------------------------------------------------------------------
    // Delay line: {frm, dat} shift register, head at index 0.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DL_DEPTH; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_next[gi] = dl_push;
            end else begin : g_body
                assign dl_next[gi] = dl_reg[gi-1];
            end
        end
    endgenerate

    assign dl_tail = dl_reg[DL_DEPTH-1];

    // ------------------------------------------------------------------
    // CRC datapath: data bytes from the tail, zeros while padding.
    // ------------------------------------------------------------------
    assign crc_byte = (state_reg == DATA && dl_tail[8]) ? dl_tail[7:0] : 8'h00;

    eth_crc32_d8 u_crc (
        .crc_prev (crc_reg),
        .data     (crc_byte),
        .crc_upd  (crc_upd)
    );

    assign byte_cnt_inc = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg
                                                    : byte_cnt_reg + 11'd1;

    // FCS goes out least significant byte first.
    assign fcs_word = ~crc_reg;
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (fcs_idx_reg)
            2'd0: fcs_byte = fcs_word[7:0];
            2'd1: fcs_byte = fcs_word[15:8];
            2'd2: fcs_byte = fcs_word[23:16];
            2'd3: fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic, evaluated per CKE beat.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pre_cnt_next  = pre_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        crc_next      = crc_reg;
        fcs_idx_next  = fcs_idx_reg;
        ifg_cnt_next  = ifg_cnt_reg;
        out_frm_next  = 1'b0;
        out_dat_next  = 8'h00;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = PRE;
                    out_frm_next  = 1'b1;
                    out_dat_next  = PREAMBLE_BYTE;
                    pre_cnt_next  = 8'd1;
                    byte_cnt_next = 11'd0;
                    crc_next      = CRC_INIT;
                    fcs_idx_next  = 2'd0;
                end
            end

            PRE: begin
                out_frm_next = 1'b1;
                crc_next     = CRC_INIT;
                if (pre_cnt_reg == PRE_LAST) begin
                    out_dat_next = SFD_BYTE;
                    state_next   = DATA;
                end else begin
                    out_dat_next = PREAMBLE_BYTE;
                    pre_cnt_next = pre_cnt_reg + 8'd1;
                end
            end

            DATA: begin
                out_frm_next = 1'b1;
                if (dl_tail[8]) begin
                    out_dat_next  = dl_tail[7:0];
                    crc_next      = crc_upd;
                    byte_cnt_next = byte_cnt_inc;
                end else if (byte_cnt_reg < MIN_CNT) begin
                    // End of data on a short frame: this beat is the first pad.
                    out_dat_next  = 8'h00;
                    crc_next      = crc_upd;
                    byte_cnt_next = byte_cnt_inc;
                    fcs_idx_next  = 2'd0;
                    state_next    = (byte_cnt_inc >= MIN_CNT) ? FCS : PAD;
                end else begin
                    // End of data, long enough: this beat is FCS byte 0.
                    out_dat_next = fcs_byte;
                    fcs_idx_next = 2'd1;
                    state_next   = FCS;
                end
            end

            PAD: begin
                out_frm_next  = 1'b1;
                out_dat_next  = 8'h00;
                crc_next      = crc_upd;
                byte_cnt_next = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_CNT) begin
                    fcs_idx_next = 2'd0;
                    state_next   = FCS;
                end
            end

            FCS: begin
                out_frm_next = 1'b1;
                out_dat_next = fcs_byte;
                if (fcs_idx_reg == 2'd3) begin
                    ifg_cnt_next = 8'd0;
                    state_next   = IFG;
                end else begin
                    fcs_idx_next = fcs_idx_reg + 2'd1;
                end
            end

            IFG: begin
                if (ifg_cnt_reg == IFG_LAST) begin
                    state_next = IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Output CKE follows input CKE every clock; everything else
    // moves only on CKE beats so OUT[8:0] holds between ticks.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_reg      <= 10'h000;
            state_reg    <= IDLE;
            prev_frm_reg <= 1'b0;
            wait_low_reg <= 1'b1;
            acc_reg      <= 1'b0;
            pre_cnt_reg  <= 8'd0;
            byte_cnt_reg <= 11'd0;
            crc_reg      <= CRC_INIT;
            fcs_idx_reg  <= 2'd0;
            ifg_cnt_reg  <= 8'd0;
            drop_cnt_reg <= 16'h0000;
            dl_reg       <= '0;
        end else begin
            out_reg[CKE] <= in_cke;
            if (in_cke) begin
                out_reg[FRM]  <= out_frm_next;
                out_reg[7:0]  <= out_dat_next;
                state_reg     <= state_next;
                prev_frm_reg  <= in_frm;
                acc_reg       <= acc_next;
                pre_cnt_reg   <= pre_cnt_next;
                byte_cnt_reg  <= byte_cnt_next;
                crc_reg       <= crc_next;
                fcs_idx_reg   <= fcs_idx_next;
                ifg_cnt_reg   <= ifg_cnt_next;
                dl_reg        <= dl_next;
                if (!in_frm) begin
                    wait_low_reg <= 1'b0;
                end
                if (reject && drop_cnt_reg != 16'hFFFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign OUT_ETH_STREAM = out_reg;
    assign BUSY           = (state_reg != IDLE);
    assign DROP_CNT       = drop_cnt_reg;

endmodule
